// File: rtl/exec_pkg.sv
// exec_pkg: shared definitions for the exec_ctrl sequencer.
//   - ALU opcode encodings (match the downstream 8-bit ALU)
//   - FSM state encodings (legacy-compatible constants)
//   - instruction field bit positions and the HALT word
//   - status flag bit indices inside flags = {C,Z,G,E}
//   - wb_flags(): status register update applied in write-back
package exec_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_CMP = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  // Instruction word: [15:13] op, [12] imm, [11:10] rd, [9:8] rs, [7:0] imm8
  localparam int OP_HI   = 15;
  localparam int OP_LO   = 13;
  localparam int IMM_BIT = 12;
  localparam int RD_LO   = 10;
  localparam int RS_LO   = 8;
  localparam int IMM8_HI = 7;
  localparam int IMM8_LO = 0;

  localparam logic [15:0] HALT_WORD = 16'hFFFF;

  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_G = 1;
  localparam int FLAG_E = 0;

  // Compare only touches G/E; every other op rewrites C/Z and keeps G/E.
  // Carry is only meaningful for ADD, so other ops clear C.
  function automatic logic [3:0] wb_flags(
    input logic [2:0] op,
    input logic [3:0] cur,
    input logic       zero,
    input logic       c,
    input logic       g,
    input logic       e
  );
    logic [3:0] f;
    f = cur;
    if (op == OP_CMP) begin
      f[FLAG_G] = g;
      f[FLAG_E] = e;
    end else begin
      f[FLAG_C] = (op == OP_ADD) ? c : 1'b0;
      f[FLAG_Z] = zero;
    end
    return f;
  endfunction

endpackage

// File: rtl/exec_regfile.sv
// exec_regfile: NREGS x DATA_W register file for exec_ctrl.
//   clk, rst_n          : clock, synchronous active-low clear of all entries
//   we, waddr, wdata    : synchronous write port
//   raddr_a / rdata_a   : combinational read port A (operand a)
//   raddr_b / rdata_b   : combinational read port B (operand b)
//   dbg_sel / dbg_data  : combinational debug read port, only when
//                         EXEC_DBG_PORT_EN is defined
module exec_regfile #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  localparam int IDX_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [IDX_W-1:0]  raddr_b,
  output logic [DATA_W-1:0] rdata_b
`ifdef EXEC_DBG_PORT_EN
  ,
  input  logic [IDX_W-1:0]  dbg_sel,
  output logic [DATA_W-1:0] dbg_data
`endif
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

`ifdef EXEC_DBG_PORT_EN
  assign dbg_data = regs[dbg_sel];
`endif

endmodule

// File: rtl/exec_ctrl.sv
// exec_ctrl: multi-cycle fetch/decode/execute/write-back sequencer that
// drives an external 8-bit ALU. One instruction takes 4 cycles
// (FETCH, DECODE, EXEC, WB). Word 16'hFFFF halts the core.
//   clk, rst_n            : clock, synchronous active-low reset
//   start                 : leave IDLE/HALT and fetch at current pc
//   imem_addr, imem_rd    : instruction fetch (data valid one cycle later)
//   imem_data             : instruction word
//   alu_a, alu_b, alu_op  : registered ALU inputs, stable through EXEC
//   alu_result, alu_greater, alu_equal, alu_carry : ALU outputs
//   flags                 : status {C,Z,G,E}
//   busy, halted, retire  : status; retire pulses once per instruction in WB
//   pc                    : program counter
// Optional: EXEC_DBG_PORT_EN adds dbg_sel/dbg_data, a combinational read
// of R[dbg_sel] that never affects execution.
module exec_ctrl
  import exec_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int NREGS  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [PC_W-1:0]   imem_addr,
  output logic              imem_rd,
  input  logic [15:0]       imem_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_greater,
  input  logic              alu_equal,
  input  logic              alu_carry,
  output logic [3:0]        flags,
  output logic              busy,
  output logic              halted,
  output logic              retire,
  output logic [PC_W-1:0]   pc
`ifdef EXEC_DBG_PORT_EN
  ,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
`endif
);

  localparam int IDX_W = $clog2(NREGS);

  logic [2:0]        state;
  logic [PC_W-1:0]   pc_q;
  logic [2:0]        ir_op;
  logic [IDX_W-1:0]  ir_rd;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] res;
  logic              res_c;
  logic              res_g;
  logic              res_e;
  logic [3:0]        flags_q;

  logic              rf_we;
  logic [DATA_W-1:0] rf_rdata_a;
  logic [DATA_W-1:0] rf_rdata_b;
  logic              dec_imm;
  logic [DATA_W-1:0] dec_imm8;

  // Register reads address straight off the incoming word during DECODE,
  // so operands are captured in the same cycle the word arrives.
  assign dec_imm  = imem_data[IMM_BIT];
  assign dec_imm8 = DATA_W'(imem_data[IMM8_HI:IMM8_LO]);
  assign rf_we    = (state == S_WB) && (ir_op != OP_CMP);

  exec_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (ir_rd),
    .wdata   (res),
    .raddr_a (imem_data[RD_LO +: IDX_W]),
    .rdata_a (rf_rdata_a),
    .raddr_b (imem_data[RS_LO +: IDX_W]),
    .rdata_b (rf_rdata_b)
`ifdef EXEC_DBG_PORT_EN
    ,
    .dbg_sel (dbg_sel[IDX_W-1:0]),
    .dbg_data(dbg_data)
`endif
  );

  // Only the op and rd fields are needed past DECODE; the rest of the
  // word is consumed while it is on imem_data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc_q    <= '0;
      ir_op   <= '0;
      ir_rd   <= '0;
      op_a    <= '0;
      op_b    <= '0;
      res     <= '0;
      res_c   <= 1'b0;
      res_g   <= 1'b0;
      res_e   <= 1'b0;
      flags_q <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (imem_data == HALT_WORD) begin
            state <= S_HALT;
          end else begin
            ir_op <= imem_data[OP_HI:OP_LO];
            ir_rd <= imem_data[RD_LO +: IDX_W];
            op_a  <= rf_rdata_a;
            op_b  <= dec_imm ? dec_imm8 : rf_rdata_b;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          res   <= alu_result;
          res_c <= alu_carry;
          res_g <= alu_greater;
          res_e <= alu_equal;
          state <= S_WB;
        end
        S_WB: begin
          flags_q <= wb_flags(ir_op, flags_q, (res == '0), res_c, res_g, res_e);
          pc_q    <= pc_q + PC_W'(1);
          state   <= S_FETCH;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign imem_rd   = (state == S_FETCH);
  assign alu_a     = op_a;
  assign alu_b     = op_b;
  assign alu_op    = ir_op;
  assign flags     = flags_q;
  assign busy      = (state == S_FETCH) || (state == S_DECODE) ||
                     (state == S_EXEC)  || (state == S_WB);
  assign halted    = (state == S_HALT);
  assign retire    = (state == S_WB);
  assign pc        = pc_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl: directed programs against exec_ctrl with an
// instruction-level reference model and per-cycle output comparison.
module tb_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  imem_addr;
  logic        imem_rd;
  logic [15:0] imem_data = '0;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic [7:0]  alu_result;
  logic        alu_greater;
  logic        alu_equal;
  logic        alu_carry;
  logic [3:0]  flags;
  logic        busy;
  logic        halted;
  logic        retire;
  logic [7:0]  pc;
`ifdef EXEC_DBG_PORT_EN
  logic [1:0]  dbg_sel = '0;
  logic [7:0]  dbg_data;
`endif

  always #5 clk = ~clk;

  exec_ctrl #(.DATA_W(8), .PC_W(8), .NREGS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imem_addr  (imem_addr),
    .imem_rd    (imem_rd),
    .imem_data  (imem_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_greater(alu_greater),
    .alu_equal  (alu_equal),
    .alu_carry  (alu_carry),
    .flags      (flags),
    .busy       (busy),
    .halted     (halted),
    .retire     (retire),
    .pc         (pc)
`ifdef EXEC_DBG_PORT_EN
    ,
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
`endif
  );

  // Instruction memory: synchronous read, data one cycle after imem_rd.
  logic [15:0] mem [256];
  always @(posedge clk) if (imem_rd) imem_data <= mem[imem_addr];

  // Bench ALU: returns {carry, result}.
  function automatic logic [8:0] alu9(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b000:  alu9 = {1'b0, a} + {1'b0, b};
      3'b001:  alu9 = {1'b0, a - b};
      3'b010:  alu9 = {1'b0, a & b};
      3'b011:  alu9 = {1'b0, a | b};
      3'b100:  alu9 = {1'b0, a ^ b};
      3'b101:  alu9 = {1'b0, a - b};
      3'b110:  alu9 = {1'b0, a << b[2:0]};
      default: alu9 = {1'b0, a >> b[2:0]};
    endcase
  endfunction

  always_comb begin
    {alu_carry, alu_result} = alu9(alu_op, alu_a, alu_b);
    alu_greater = (alu_a > alu_b);
    alu_equal   = (alu_a == alu_b);
  end

  // Reference model: instruction-level ISS with a phase count
  // (-1 idle, -2 halted, 0..3 = cycle within the current instruction).
  localparam int PH_IDLE = -1;
  localparam int PH_HALT = -2;
  int          m_ph = PH_IDLE;
  logic [7:0]  m_pc;
  logic [7:0]  m_R [4];
  logic [3:0]  m_flags;
  logic [2:0]  m_op;
  logic [1:0]  m_rd;
  logic [7:0]  m_a;
  logic [7:0]  m_b;

  always @(posedge clk) begin
    logic [15:0] w;
    logic [8:0]  r;
    if (!rst_n) begin
      m_ph = PH_IDLE; m_pc = '0; m_flags = '0;
      for (int i = 0; i < 4; i++) m_R[i] = '0;
    end else begin
      case (m_ph)
        PH_IDLE, PH_HALT: if (start) m_ph = 0;
        0: m_ph = 1;
        1: begin
          w = mem[m_pc];
          if (w == 16'hFFFF) m_ph = PH_HALT;
          else begin
            m_op = w[15:13];
            m_rd = w[11:10];
            m_a  = m_R[w[11:10]];
            m_b  = w[12] ? w[7:0] : m_R[w[9:8]];
            m_ph = 2;
          end
        end
        2: m_ph = 3;
        default: begin
          r = alu9(m_op, m_a, m_b);
          if (m_op == 3'b101) begin
            m_flags[1] = (m_a > m_b);
            m_flags[0] = (m_a == m_b);
          end else begin
            m_R[m_rd]  = r[7:0];
            m_flags[3] = (m_op == 3'b000) ? r[8] : 1'b0;
            m_flags[2] = (r[7:0] == 8'h00);
          end
          m_pc = m_pc + 8'd1;
          m_ph = 0;
        end
      endcase
    end
  end

  int   checks = 0;
  int   failures = 0;
  bit   chk_en = 1'b0;
  int   nret = 0;
  int   nfetch = 0;
  logic [7:0] last_a, last_b, last_fetch;
  logic [2:0] last_op;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",    32'(busy),    32'(m_ph >= 0));
      chk("halted",  32'(halted),  32'(m_ph == PH_HALT));
      chk("imem_rd", 32'(imem_rd), 32'(m_ph == 0));
      chk("retire",  32'(retire),  32'(m_ph == 3));
      chk("pc",      32'(pc),      32'(m_pc));
      chk("flags",   32'(flags),   32'(m_flags));
      if (m_ph == 0) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
      if (m_ph == 2) begin
        chk("alu_a",  32'(alu_a),  32'(m_a));
        chk("alu_b",  32'(alu_b),  32'(m_b));
        chk("alu_op", 32'(alu_op), 32'(m_op));
        last_a = alu_a; last_b = alu_b; last_op = alu_op;
      end
    end
    if (retire === 1'b1) nret++;
    if (imem_rd === 1'b1) begin nfetch++; last_fetch = imem_addr; end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    rst_n = 1'b0; start = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    nret = 0; nfetch = 0;
  endtask

  task automatic pulse_start;
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 256; i++) mem[i] = 16'hFFFF;
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (halted !== 1'b1 && n < budget) begin cyc(1); n++; end
    chk("halt_timeout", 32'(halted), 32'd1);
  endtask

  task automatic wait_ret(input int target, input int budget);
    int n = 0;
    while (nret < target && n < budget) begin cyc(1); n++; end
    chk("retire_timeout", 32'(nret), 32'(target));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    clear_mem();
    cyc(2);
    chk_en = 1'b1;

    // Reset / idle
    do_reset();
    chk("rst_alu_a",  32'(alu_a),  32'd0);
    chk("rst_alu_b",  32'(alu_b),  32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_pc",     32'(pc),     32'd0);
    chk("rst_flags",  32'(flags),  32'd0);
    cyc(6);
    chk("idle_busy",  32'(busy),    32'd0);
    chk("idle_rd",    32'(imem_rd), 32'd0);

    // ADD with carry: R0=0xF0, then +0x20 -> 0x10, C=1
    clear_mem();
    mem[0] = 16'h10F0; mem[1] = 16'h1020;
    do_reset();
    pulse_start();
    wait_halt(40);
    chk("add_nret",  32'(nret),    32'd2);
    chk("add_flags", 32'(flags),   32'h8);
    chk("add_pc",    32'(pc),      32'd2);
    chk("add_r0",    32'(m_R[0]),  32'h10);
    chk("add_a",     32'(last_a),  32'hF0);
    chk("add_b",     32'(last_b),  32'h20);
    chk("add_op",    32'(last_op), 32'd0);

    // Compare leaves registers and C/Z alone; restart after imem change
    clear_mem();
    mem[0] = 16'h1405; mem[1] = 16'h1805; mem[2] = 16'h10FF;
    mem[3] = 16'h1001; mem[4] = 16'hA600;
    do_reset();
    pulse_start();
    wait_halt(60);
    chk("cmp_nret",  32'(nret),  32'd5);
    chk("cmp_flags", 32'(flags), 32'hD);
    chk("cmp_pc",    32'(pc),    32'd5);
    mem[5] = 16'h7400;
    pulse_start();
    wait_halt(30);
    chk("or_nret",  32'(nret),    32'd6);
    chk("or_a",     32'(last_a),  32'h05);
    chk("or_op",    32'(last_op), 32'd3);
    chk("or_flags", 32'(flags),   32'h1);
    chk("or_pc",    32'(pc),      32'd6);

    // Halt and restart re-fetches the HALT word
    clear_mem();
    mem[0] = 16'h1001;
    do_reset();
    pulse_start();
    wait_halt(30);
    chk("halt_nret",   32'(nret),   32'd1);
    chk("halt_pc",     32'(pc),     32'd1);
    chk("halt_fetch",  32'(nfetch), 32'd2);
    pulse_start();
    wait_halt(20);
    chk("rehalt_nret",  32'(nret),       32'd1);
    chk("rehalt_pc",    32'(pc),         32'd1);
    chk("rehalt_fetch", 32'(nfetch),     32'd3);
    chk("rehalt_addr",  32'(last_fetch), 32'd1);

    // PC wrap: 256 x ADD R3,#1
    for (int i = 0; i < 256; i++) mem[i] = 16'h1C01;
    do_reset();
    pulse_start();
    wait_ret(256, 1100);
    cyc(1);
    chk("wrap_pc",    32'(pc),     32'd0);
    chk("wrap_flags", 32'(flags),  32'hC);
    chk("wrap_r3",    32'(m_R[3]), 32'd0);
    cyc(2);
    chk("wrap_a",     32'(last_a), 32'd0);

    // Reset during EXEC of SUB R1,#3
    clear_mem();
    mem[0] = 16'h1407; mem[1] = 16'h3403; mem[2] = 16'h7400;
    do_reset();
    pulse_start();
    wait_ret(1, 20);
    for (int n = 0; n < 10 && m_ph != 2; n++) cyc(1);
    chk("mid_exec_op", 32'(alu_op), 32'd1);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    chk("mid_busy",  32'(busy),   32'd0);
    chk("mid_pc",    32'(pc),     32'd0);
    chk("mid_alu_a", 32'(alu_a),  32'd0);
    cyc(3);
    chk("mid_nret",  32'(nret),   32'd1);
    chk("mid_idle",  32'(busy),   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
